// File: rtl/conv_accum_sched_if.sv
// rtl/conv_accum_sched_if.sv - product-beat input and pixel-result output handshakes
interface conv_accum_sched_if #(
    parameter int DATA_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [9*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_accum_sched.sv
// rtl/conv_accum_sched.sv - sequences 9-way tree-add across channel groups, ReLU per pixel
module conv_accum_sched #(
    parameter int DATA_W = 16,
    parameter int GRP_W  = 4,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [GRP_W-1:0]     cfg_groups,
    input  logic [PIX_W-1:0]     cfg_pixels,
    input  logic [DATA_W-1:0]    cfg_bias,
    output logic                 busy,
    output logic                 done,
    conv_accum_sched_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   bias_r;
    logic [DATA_W-1:0]   result;
    logic [GRP_W-1:0]    grp;
    logic [GRP_W-1:0]    groups_r;
    logic [PIX_W-1:0]    pix;
    logic [PIX_W-1:0]    pixels_r;
    logic                last_r;
    logic [DATA_W-1:0]   sum;
    logic                grp_last;
    logic                pix_last;
    logic                beat;

    // Wrapping two's-complement add, so tree shape does not matter.
    always_comb begin
        sum = acc;
        for (int k = 0; k < 9; k++) begin
            sum = sum + bus.in_data[DATA_W*k +: DATA_W];
        end
    end

    assign grp_last = (grp == GRP_W'(groups_r - 1'b1));
    assign pix_last = (pix == PIX_W'(pixels_r - 1'b1));
    assign beat     = (state == ACCUM) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (bus.in_valid && grp_last) state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = pix_last ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == OUT);
        bus.out_last  = (state == OUT) && last_r;
        done          = (state == DONE);
    end

    assign bus.out_data = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            bias_r   <= '0;
            result   <= '0;
            grp      <= '0;
            groups_r <= '0;
            pix      <= '0;
            pixels_r <= '0;
            last_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        groups_r <= (cfg_groups == '0) ? GRP_W'(1) : cfg_groups;
                        pixels_r <= (cfg_pixels == '0) ? PIX_W'(1) : cfg_pixels;
                        bias_r   <= cfg_bias;
                        acc      <= cfg_bias;
                        grp      <= '0;
                        pix      <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (grp_last) begin
                            result <= sum[DATA_W-1] ? '0 : sum;
                            last_r <= pix_last;
                        end else begin
                            acc <= sum;
                            grp <= grp + GRP_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready && !pix_last) begin
                        acc <= bias_r;
                        grp <= '0;
                        pix <= pix + PIX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum_sched.sv
// tb/tb_conv_accum_sched.sv - directed bench for conv_accum_sched
module tb_conv_accum_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_groups;
    logic [7:0]  cfg_pixels;
    logic [15:0] cfg_bias;
    logic        busy;
    logic        done;
    int          total;
    int          bad;

    conv_accum_sched_if #(.DATA_W(16)) bus ();

    conv_accum_sched #(.DATA_W(16), .GRP_W(4), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_groups (cfg_groups),
        .cfg_pixels (cfg_pixels),
        .cfg_bias   (cfg_bias),
        .busy       (busy),
        .done       (done),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < 9; k++) begin
            bus.in_data[16*k +: 16] = 16'(v);
        end
    endtask

    task automatic kick(input int g, input int p, input int b);
        cfg_groups = 4'(g);
        cfg_pixels = 8'(p);
        cfg_bias   = 16'(b);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    int vals [3][2];
    int expv [3];

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; cfg_groups = '0; cfg_pixels = '0; cfg_bias = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out_last", {31'd0, bus.out_last}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_out_data", {16'd0, bus.out_data}, 0);
        rst = 1'b0;
        step();

        // single group: 5 + 9*10 = 95
        kick(1, 1, 5);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_in_ready", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1; set_all(10);
        step();
        bus.in_valid = 1'b0;
        chk("t1_out_valid", {31'd0, bus.out_valid}, 1);
        chk("t1_out_data", {16'd0, bus.out_data}, 95);
        chk("t1_out_last", {31'd0, bus.out_last}, 1);
        chk("t1_in_ready_out", {31'd0, bus.in_ready}, 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_done_out_valid", {31'd0, bus.out_valid}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_idle_busy", {31'd0, busy}, 0);
        chk("t1_done_clear", {31'd0, done}, 0);
        step();
        chk("t1_start_in_done_ignored", {31'd0, busy}, 0);

        // negative intermediates: -90 -90 +270 = 90
        kick(3, 1, 0);
        bus.in_valid = 1'b1;
        chk("t2_rdy0", {31'd0, bus.in_ready}, 1);
        set_all(-10); step();
        chk("t2_rdy1", {31'd0, bus.in_ready}, 1);
        chk("t2_no_early_out", {31'd0, bus.out_valid}, 0);
        set_all(-10); step();
        chk("t2_rdy2", {31'd0, bus.in_ready}, 1);
        set_all(30); step();
        bus.in_valid = 1'b0;
        chk("t2_rdy_out", {31'd0, bus.in_ready}, 0);
        chk("t2_out_data", {16'd0, bus.out_data}, 90);
        chk("t2_out_last", {31'd0, bus.out_last}, 1);
        bus.out_ready = 1'b1; step(); step(); bus.out_ready = 1'b0;
        chk("t2_idle", {31'd0, busy}, 0);

        // ReLU clamp: -100 + 45 + 45 = -10 -> 0
        kick(2, 1, -100);
        bus.in_valid = 1'b1; set_all(5); step(); step();
        bus.in_valid = 1'b0;
        chk("t3_out_valid", {31'd0, bus.out_valid}, 1);
        chk("t3_out_data", {16'd0, bus.out_data}, 0);
        bus.out_ready = 1'b1; step(); step(); bus.out_ready = 1'b0;

        // backpressure, gaps, bias 7 re-applied per pixel
        vals[0][0] = 1;  vals[0][1] = 2;  expv[0] = 34;
        vals[1][0] = 3;  vals[1][1] = -1; expv[1] = 25;
        vals[2][0] = 4;  vals[2][1] = -3; expv[2] = 16;
        kick(2, 3, 7);
        for (int p = 0; p < 3; p++) begin
            for (int g = 0; g < 2; g++) begin
                for (int gap = 0; gap <= (p + g) % 2; gap++) begin
                    bus.in_valid = 1'b0;
                    step();
                    chk($sformatf("t4_hold_p%0d_g%0d", p, g), {31'd0, bus.in_ready}, 1);
                end
                bus.in_valid = 1'b1; set_all(vals[p][g]);
                step();
            end
            bus.in_valid = 1'b0; set_all(0);
            for (int s = 0; s < 5; s++) begin
                chk($sformatf("t4_valid_p%0d_s%0d", p, s), {31'd0, bus.out_valid}, 1);
                chk($sformatf("t4_data_p%0d_s%0d", p, s), {16'd0, bus.out_data}, 32'(expv[p]));
                chk($sformatf("t4_last_p%0d_s%0d", p, s), {31'd0, bus.out_last}, (p == 2) ? 1 : 0);
                chk($sformatf("t4_rdy_p%0d_s%0d", p, s), {31'd0, bus.in_ready}, 0);
                chk($sformatf("t4_nodone_p%0d_s%0d", p, s), {31'd0, done}, 0);
                if (s == 4) bus.out_ready = 1'b1;
                step();
            end
            bus.out_ready = 1'b0;
        end
        chk("t4_done", {31'd0, done}, 1);
        step();
        chk("t4_done_once", {31'd0, done}, 0);
        chk("t4_idle", {31'd0, busy}, 0);

        // zero config treated as 1/1; 0x7FFF + 1 wraps negative -> 0
        kick(0, 0, 16'h7FFF);
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_data[16*4 +: 16] = 16'd1;
        step();
        bus.in_valid = 1'b0;
        chk("t5_out_valid", {31'd0, bus.out_valid}, 1);
        chk("t5_out_data", {16'd0, bus.out_data}, 0);
        chk("t5_out_last", {31'd0, bus.out_last}, 1);
        bus.out_ready = 1'b1; step();
        chk("t5_done", {31'd0, done}, 1);
        step(); bus.out_ready = 1'b0;

        // ignored start mid-job, then reset mid-ACCUM of pixel 2
        kick(2, 3, 0);
        cfg_groups = 4'd1; start = 1'b1;
        bus.in_valid = 1'b1; set_all(1);
        step();
        start = 1'b0;
        chk("t6_start_ignored", {31'd0, bus.out_valid}, 0);
        chk("t6_still_accum", {31'd0, bus.in_ready}, 1);
        step();
        bus.in_valid = 1'b0;
        chk("t6_pix1_data", {16'd0, bus.out_data}, 18);
        chk("t6_pix1_last", {31'd0, bus.out_last}, 0);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("t6_pix2_accum", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("t6_rst_data", {16'd0, bus.out_data}, 0);
        kick(1, 1, 3);
        bus.in_valid = 1'b1; set_all(2); step();
        bus.in_valid = 1'b0;
        chk("t6_clean_data", {16'd0, bus.out_data}, 21);
        chk("t6_clean_last", {31'd0, bus.out_last}, 1);
        bus.out_ready = 1'b1; step();
        chk("t6_clean_done", {31'd0, done}, 1);
        step(); bus.out_ready = 1'b0;
        chk("t6_clean_idle", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_accum_sched.md
Name: conv_accum_sched

Overview:
- Sequences the 9-input signed tree-add datapath across input-channel groups to produce one ReLU'd 16-bit output pixel per sequence.
- Each pixel takes `cfg_groups` beats of 9 products. The bias is added once per pixel. The running sum is held un-clamped, and ReLU is applied only after the last group.
- Sits between the multiplier array (upstream, valid/ready) and the output buffer writer (downstream, valid/ready) in the convolution layer.

Parameters:
- DATA_W, 16, width of products, bias, accumulator and result.
- GRP_W, 4, width of group-count config and group counter.
- PIX_W, 8, width of pixel-count config and pixel counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start pulse; accepted only in IDLE
- cfg_groups  in  GRP_W  channel groups per pixel, unsigned; 0 treated as 1
- cfg_pixels  in  PIX_W  pixels per job, unsigned; 0 treated as 1
- cfg_bias  in  DATA_W  signed bias per pixel
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  upstream product beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  9*DATA_W  nine signed products; element k at [DATA_W*k +: DATA_W], k=0..8
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  ReLU'd pixel result
- out_last  out  1  high with out_valid on the last pixel of the job
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst=1 at edge): state=IDLE; acc, grp, pix, result regs = 0; busy=0, in_ready=0, out_valid=0, out_last=0, done=0, out_data=0. Reset mid-job aborts the job and any pending result is dropped.
- States: IDLE, ACCUM, OUT, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: latch groups = max(cfg_groups,1), pixels = max(cfg_pixels,1), bias = cfg_bias; acc<=cfg_bias; grp<=0; pix<=0; go to ACCUM.
  - start outside IDLE is ignored; config is not re-sampled mid-job.
- ACCUM:
  - in_ready=1 (combinational from state only, never from in_valid).
  - On in_valid&&in_ready: sum = acc + the nine elements. All arithmetic is DATA_W-bit two's complement, wrapping with no saturation (result is order-independent mod 2^DATA_W).
  - If grp==groups-1: result<=(sum[DATA_W-1] ? 0 : sum); out_last<=(pix==pixels-1); go to OUT.
  - Else: acc<=sum; grp<=grp+1.
  - No beat is accepted while in_valid=0; state is held.
- OUT:
  - in_ready=0, out_valid=1, out_data=result.
  - out_data and out_last are held stable while out_ready=0.
  - On out_ready:
    - If pix==pixels-1: go to DONE.
    - Else: acc<=bias; grp<=0; pix<=pix+1; go to ACCUM.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. A start in the DONE cycle is ignored.
- Latency: out_valid asserts the cycle after the last group beat is accepted. Minimum pixel period is groups+1 cycles with out_ready tied high.
- Throughput: one beat per cycle in ACCUM, with no bubbles between groups of a pixel.
- Intermediate negatives are kept: ReLU is applied only to the final sum, never per group.
- All outputs are registered or decoded from state only, with no combinational path from in_valid or out_ready to outputs.

Test Plan:
- Single group: rst; start with groups=1, pixels=1, bias=5; beat products all 10. Required: out_data=95, out_last=1 one cycle after the beat; then done pulse; busy drops.
- Multi-group with negative intermediate: groups=3, pixels=1, bias=0; beats of all -10, all -10, all 30. Required: single out_data=90; no per-group clamp; in_ready=1 for exactly the 3 accepting cycles.
- ReLU clamp: groups=2, bias=-100; beats all 5 and all 5. Sum is -10, so required out_data=0.
- Backpressure and stalls: groups=2, pixels=3, random in_valid gaps, out_ready low 4 cycles per result.
  - Required: out_data stable while stalled; in_ready=0 in OUT.
  - 3 results, bias re-applied each pixel; out_last only on the third; one done pulse.
- Zero config and wrap: cfg_groups=0, cfg_pixels=0, bias=0x7FFF; beat with one element =1, rest 0.
  - Required: treated as 1/1; sum wraps to 0x8000, so out_data=0.
- Reset and ignored start: rst asserted mid-ACCUM of pixel 2.
  - Required next cycle: IDLE, out_valid=0, busy=0.
  - start pulsed while busy is ignored; a new start after reset runs a clean job.
